// File: rtl/eth_decap.sv
// eth_decap: strips a 48-byte Ethernet/IPv4/UDP/tcap header from 64-bit AXI-Stream
// frames and writes the payload beats into a TLP FIFO.
//
// Ports:
//   clk156, sys_rst              clock, asynchronous active-high reset
//   s_axis_t{valid,ready,data,keep,last,user}  ingress stream (wire byte 0 in [7:0])
//   wr_en, din[82:0], full       FIFO write side:
//                                din = {dir, tkeep, tdata, tuser[7:0], tlast}
//   rx_pkt_cnt, rx_drop_cnt      frames forwarded / frames discarded
//   last_seq, seq_err_cnt        tcap sequence of the last accepted frame, gap count
//   dbg_state                    current FSM state (RX_HDR=0, RX_DATA=1, RX_DROP=2)
//
// Handshake: an ingress beat moves only on a cycle where s_axis_tvalid and
// s_axis_tready are both high at the rising edge; nothing changes otherwise.
// The FIFO side has no ready: wr_en is a strobe, and it is never raised while
// full is high, because in RX_DATA s_axis_tready is !full.
module eth_decap #(
  parameter logic [15:0] udp_dport = 16'h3776,
  parameter logic [15:0] eth_proto = 16'h0800
) (
  input  logic        clk156,
  input  logic        sys_rst,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        wr_en,
  output logic [82:0] din,
  input  logic        full,
  output logic [31:0] rx_pkt_cnt,
  output logic [31:0] rx_drop_cnt,
  output logic [31:0] last_seq,
  output logic [31:0] seq_err_cnt,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    RX_HDR  = 2'd0,
    RX_DATA = 2'd1,
    RX_DROP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  beat_q, beat_d;
  logic        bad_q, bad_d;
  logic [1:0]  dir_q, dir_d;
  logic [31:0] seq_q, seq_d;
  logic [31:0] pkt_q, pkt_d;
  logic [31:0] drop_q, drop_d;
  logic [31:0] last_q, last_d;
  logic [31:0] err_q, err_d;

  logic        xfer;
  logic        hdr_fail;
  logic [7:0]  keep_rev;
  logic [63:0] data_swap;

  assign s_axis_tready = (state_q == RX_DATA) ? !full : 1'b1;
  assign xfer          = s_axis_tvalid && s_axis_tready;

  // Header field checks for the beat currently presented. Byte N lives in
  // beat N/8 at lane N%8, so e.g. bytes 12-13 are lanes 4-5 of beat 1.
  always_comb begin
    hdr_fail = 1'b0;
    case (beat_q)
      3'd1: hdr_fail = (s_axis_tdata[39:32] != eth_proto[15:8]) ||
                       (s_axis_tdata[47:40] != eth_proto[7:0])  ||
                       (s_axis_tdata[55:48] != 8'h45);
      3'd2: hdr_fail = (s_axis_tdata[63:56] != 8'h11);
      3'd4: hdr_fail = (s_axis_tdata[39:32] != udp_dport[15:8]) ||
                       (s_axis_tdata[47:40] != udp_dport[7:0]);
      default: hdr_fail = 1'b0;
    endcase
  end

  // FIFO word: keep bits reversed and data byte-swapped to match the
  // encapsulator's FIFO layout (byte 0 in the top lane).
  always_comb begin
    keep_rev  = '0;
    data_swap = '0;
    for (int i = 0; i < 8; i++) begin
      keep_rev[i]            = s_axis_tkeep[7-i];
      data_swap[8*i +: 8]    = s_axis_tdata[8*(7-i) +: 8];
    end
  end

  assign din = {dir_q, keep_rev, data_swap, 7'b0, s_axis_tuser & s_axis_tlast, s_axis_tlast};

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    bad_d   = bad_q;
    dir_d   = dir_q;
    seq_d   = seq_q;
    pkt_d   = pkt_q;
    drop_d  = drop_q;
    last_d  = last_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    case (state_q)
      RX_HDR: begin
        if (xfer) begin
          if (s_axis_tlast) begin
            // Runt or header-only frame: nothing to forward.
            beat_d = 3'd0;
            bad_d  = 1'b0;
            drop_d = drop_q + 32'd1;
          end else if (beat_q == 3'd5) begin
            beat_d  = 3'd0;
            bad_d   = 1'b0;
            dir_d   = s_axis_tdata[23:22];
            seq_d   = {s_axis_tdata[39:32], s_axis_tdata[47:40],
                       s_axis_tdata[55:48], s_axis_tdata[63:56]};
            state_d = bad_q ? RX_DROP : RX_DATA;
          end else begin
            beat_d = beat_q + 3'd1;
            bad_d  = bad_q | hdr_fail;
          end
        end
      end
      RX_DATA: begin
        wr_en = xfer;
        if (xfer && s_axis_tlast) begin
          state_d = RX_HDR;
          pkt_d   = pkt_q + 32'd1;
          last_d  = seq_q;
          // The first frame after reset has no predecessor to compare with.
          if ((pkt_q != 32'd0) && (seq_q != last_q + 32'd1))
            err_d = err_q + 32'd1;
        end
      end
      RX_DROP: begin
        if (xfer && s_axis_tlast) begin
          state_d = RX_HDR;
          drop_d  = drop_q + 32'd1;
        end
      end
      default: state_d = RX_HDR;
    endcase
  end

  always_ff @(posedge clk156 or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= RX_HDR;
      beat_q  <= 3'd0;
      bad_q   <= 1'b0;
      dir_q   <= 2'd0;
      seq_q   <= 32'd0;
      pkt_q   <= 32'd0;
      drop_q  <= 32'd0;
      last_q  <= 32'd0;
      err_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      bad_q   <= bad_d;
      dir_q   <= dir_d;
      seq_q   <= seq_d;
      pkt_q   <= pkt_d;
      drop_q  <= drop_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign rx_pkt_cnt  = pkt_q;
  assign rx_drop_cnt = drop_q;
  assign last_seq    = last_q;
  assign seq_err_cnt = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_eth_decap.sv
// tb_eth_decap: scoreboard bench for eth_decap. Expected FIFO words are queued
// as payload beats are driven and compared whenever the DUT strobes wr_en.
module tb_eth_decap;

  logic        clk156 = 1'b0;
  logic        sys_rst;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic        wr_en;
  logic [82:0] din;
  logic        full;
  logic [31:0] rx_pkt_cnt;
  logic [31:0] rx_drop_cnt;
  logic [31:0] last_seq;
  logic [31:0] seq_err_cnt;
  logic [1:0]  dbg_state;

  logic [82:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  logic [31:0] m_pkt, m_drop, m_last, m_err;

  eth_decap dut (
    .clk156(clk156), .sys_rst(sys_rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .wr_en(wr_en), .din(din), .full(full),
    .rx_pkt_cnt(rx_pkt_cnt), .rx_drop_cnt(rx_drop_cnt),
    .last_seq(last_seq), .seq_err_cnt(seq_err_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk156 = ~clk156;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [82:0] got, input logic [82:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] k);
    for (int i = 0; i < 8; i++) rev8[i] = k[7-i];
  endfunction

  function automatic logic [63:0] bswap64(input logic [63:0] d);
    for (int i = 0; i < 8; i++) bswap64[8*i +: 8] = d[8*(7-i) +: 8];
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk156) begin
    if (wr_en === 1'b1) begin
      if (full === 1'b1) check("wr_en_while_full", 1, 0);
      if (exp_q.size() == 0) check("unexpected_wr_en", 1, 0);
      else check("din", din, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  // Wait until the presented beat is accepted; returns #1 after that edge.
  task automatic xfer();
    int n = 0;
    forever begin
      @(negedge clk156);
      if (s_axis_tready === 1'b1) break;
      n++;
      if (n > 500) begin
        check("handshake_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk156);
    #1;
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    repeat (n) @(posedge clk156);
    #1;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_pkt"},  rx_pkt_cnt,  m_pkt);
    check({tag, "_drop"}, rx_drop_cnt, m_drop);
    check({tag, "_last"}, last_seq,    m_last);
    check({tag, "_err"},  seq_err_cnt, m_err);
  endtask

  // npay=0 gives a header-only frame (tlast on beat 5). runt_at>=0 ends the
  // frame on that header beat. stall_at/rst_at index payload beats.
  task automatic send_frame(input logic [15:0] proto, input logic [15:0] dport,
                            input logic [1:0] dir, input logic [31:0] seq,
                            input int npay, input int runt_at,
                            input int stall_at, input int rst_at);
    logic [7:0]  hdr[48];
    logic [63:0] d;
    logic [7:0]  k;
    logic        u, l;
    logic [7:0]  last_keeps[4];
    bit          accept;
    last_keeps[0] = 8'hff; last_keeps[1] = 8'h0f;
    last_keeps[2] = 8'h01; last_keeps[3] = 8'h3f;
    accept = (proto == 16'h0800) && (dport == 16'h3776) && (runt_at < 0) && (npay > 0);
    for (int i = 0; i < 48; i++) hdr[i] = 8'($urandom_range(0, 255));
    hdr[12] = proto[15:8]; hdr[13] = proto[7:0];
    hdr[14] = 8'h45;       hdr[23] = 8'h11;
    hdr[36] = dport[15:8]; hdr[37] = dport[7:0];
    hdr[42] = {dir, hdr[42][5:0]};
    hdr[44] = seq[31:24];  hdr[45] = seq[23:16];
    hdr[46] = seq[15:8];   hdr[47] = seq[7:0];
    for (int b = 0; b < 6; b++) begin
      for (int j = 0; j < 8; j++) d[8*j +: 8] = hdr[8*b+j];
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tkeep  = 8'hff;
      s_axis_tlast  = (b == runt_at) || (b == 5 && npay == 0);
      s_axis_tuser  = 1'b0;
      xfer();
      if (s_axis_tlast) begin
        m_drop++;
        s_axis_tvalid = 1'b0;
        return;
      end
    end
    for (int p = 0; p < npay; p++) begin
      if (p == rst_at) begin
        s_axis_tvalid = 1'b0;
        sys_rst = 1'b1;
        #1;
        check("rst_wr_en", wr_en, 0);
        check("rst_pkt", rx_pkt_cnt, 0);
        check("rst_drop", rx_drop_cnt, 0);
        check("rst_last", last_seq, 0);
        check("rst_err", seq_err_cnt, 0);
        check("rst_state", dbg_state, 0);
        @(negedge clk156);
        sys_rst = 1'b0;
        @(posedge clk156);
        #1;
        check("rst_tready", s_axis_tready, 1);
        exp_q.delete();
        m_pkt = 0; m_drop = 0; m_last = 0; m_err = 0;
        return;
      end
      l = (p == npay - 1);
      d = {$urandom, $urandom};
      k = l ? last_keeps[$urandom_range(0, 3)] : 8'hff;
      u = 1'($urandom_range(0, 1));
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      s_axis_tlast  = l;
      s_axis_tuser  = u;
      if (accept) exp_q.push_back({dir, rev8(k), bswap64(d), 7'b0, u & l, l});
      if (p == stall_at && accept) begin
        full = 1'b1;
        repeat (5) begin
          @(negedge clk156);
          check("stall_tready", s_axis_tready, 0);
          check("stall_wr_en", wr_en, 0);
        end
        @(posedge clk156);
        #1;
        full = 1'b0;
      end
      xfer();
    end
    s_axis_tvalid = 1'b0;
    if (accept) begin
      if (m_pkt != 0 && seq != m_last + 32'd1) m_err++;
      m_pkt++;
      m_last = seq;
    end else begin
      m_drop++;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    sys_rst = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
    s_axis_tlast = 1'b0;  s_axis_tuser = 1'b0; full = 1'b0;
    m_pkt = 0; m_drop = 0; m_last = 0; m_err = 0;
    repeat (3) @(posedge clk156);
    #1;
    check("reset_wr_en", wr_en, 0);
    check("reset_state", dbg_state, 0);
    check_counters("reset");
    @(negedge clk156);
    sys_rst = 1'b0;
    @(posedge clk156);
    #1;
    check("reset_tready", s_axis_tready, 1);

    // Basic valid frame: 80 bytes, dir 01, seq 1.
    send_frame(16'h0800, 16'h3776, 2'b01, 32'd1, 4, -1, -1, -1);
    idle(2); check_counters("valid1");
    check("valid1_pkt_const", rx_pkt_cnt, 1);
    check("valid1_last_const", last_seq, 1);

    // Wrong UDP port, then a normal frame.
    send_frame(16'h0800, 16'h1234, 2'b01, 32'd2, 4, -1, -1, -1);
    idle(1); check_counters("bad_dport");
    send_frame(16'h0800, 16'h3776, 2'b10, 32'd2, 4, -1, -1, -1);
    idle(1); check_counters("after_bad_dport");

    // Runt ending on beat 3, then a normal frame.
    send_frame(16'h0800, 16'h3776, 2'b11, 32'd3, 4, 3, -1, -1);
    idle(1); check_counters("runt");
    send_frame(16'h0800, 16'h3776, 2'b00, 32'd3, 3, -1, -1, -1);
    idle(1); check_counters("after_runt");

    // FIFO full for 5 cycles on payload beat 2.
    send_frame(16'h0800, 16'h3776, 2'b01, 32'd4, 4, -1, 2, -1);
    idle(1); check_counters("stall");

    // Header-only frame, wrong EtherType, single-beat payload.
    send_frame(16'h0800, 16'h3776, 2'b01, 32'd5, 0, -1, -1, -1);
    idle(1); check_counters("hdr_only");
    send_frame(16'h86dd, 16'h3776, 2'b01, 32'd5, 2, -1, -1, -1);
    idle(1); check_counters("bad_proto");
    send_frame(16'h0800, 16'h3776, 2'b10, 32'd5, 1, -1, -1, -1);
    idle(1); check_counters("one_beat");

    // Reset in the middle of payload beat 2.
    send_frame(16'h0800, 16'h3776, 2'b01, 32'd6, 4, -1, -1, 2);
    idle(1); check_counters("mid_rst");

    // Sequence gaps and 32-bit wrap.
    send_frame(16'h0800, 16'h3776, 2'b01, 32'd5, 4, -1, -1, -1);
    idle(1); check("post_rst_pkt_const", rx_pkt_cnt, 1);
    send_frame(16'h0800, 16'h3776, 2'b01, 32'd6, 2, -1, -1, -1);
    idle($urandom_range(0, 3));
    send_frame(16'h0800, 16'h3776, 2'b01, 32'd8, 3, -1, -1, -1);
    idle($urandom_range(0, 3));
    send_frame(16'h0800, 16'h3776, 2'b01, 32'hffffffff, 2, -1, -1, -1);
    idle($urandom_range(0, 3));
    send_frame(16'h0800, 16'h3776, 2'b01, 32'd0, 5, -1, -1, -1);
    idle(1); check_counters("seq");
    check("seq_err_const", seq_err_cnt, 2);
    check("seq_last_const", last_seq, 0);

    // A few random-length back-to-back frames.
    for (int f = 0; f < 6; f++) begin
      send_frame(16'h0800, ($urandom_range(0, 3) == 0) ? 16'h0042 : 16'h3776,
                 2'($urandom_range(0, 3)), 32'(f + 1), $urandom_range(1, 6), -1, -1, -1);
      idle($urandom_range(0, 2));
    end
    idle(2); check_counters("random");

    check("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
